// File: rtl/axis_pattern_master.sv
// AXI4-Stream pattern master: emits frames of incrementing words after a
// programmable idle gap, either once per START or continuously until STOP.
module axis_pattern_master #(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M_START_COUNT      = 32,
    parameter int unsigned C_NUM_WORDS          = 8,
    parameter int unsigned C_MODE               = 0
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESETN,
    input  logic                                START,
    input  logic                                STOP,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    output logic                                BUSY,
    output logic                                FRAME_DONE,
    output logic [15:0]                         FRAME_CNT
);

    localparam int unsigned DW    = C_M_AXIS_TDATA_WIDTH;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned GAP_W = 8;
    localparam int unsigned IDX_W = (C_NUM_WORDS > 1) ? $clog2(C_NUM_WORDS) : 1;
    localparam int unsigned CNT_W = 16;

    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(C_M_START_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(C_NUM_WORDS - 1);
    localparam bit               CONTINUOUS = (C_MODE != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t             state_q,      state_nxt;
    logic [GAP_W-1:0]   gap_q,        gap_nxt;
    logic [IDX_W-1:0]   beat_q,       beat_nxt;
    logic [DW-1:0]      word_q,       word_nxt;
    logic               tvalid_q,     tvalid_nxt;
    logic [DW-1:0]      tdata_q,      tdata_nxt;
    logic               tlast_q,      tlast_nxt;
    logic               busy_q,       busy_nxt;
    logic               done_q,       done_nxt;
    logic [CNT_W-1:0]   fcnt_q,       fcnt_nxt;
    logic               handshake;

    assign handshake = tvalid_q & M_AXIS_TREADY;

    // Next-state and next-output logic; every register holds unless told otherwise.
    always_comb begin
        state_nxt  = state_q;
        gap_nxt    = gap_q;
        beat_nxt   = beat_q;
        word_nxt   = word_q;
        tvalid_nxt = tvalid_q;
        tdata_nxt  = tdata_q;
        tlast_nxt  = tlast_q;
        done_nxt   = 1'b0;
        fcnt_nxt   = fcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    gap_nxt   = GAP_LOAD;
                    state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (STOP) begin
                    state_nxt = ST_IDLE;
                end else if (gap_q == '0) begin
                    state_nxt  = ST_SEND;
                    tvalid_nxt = 1'b1;
                    tdata_nxt  = word_q;
                    tlast_nxt  = (beat_q == IDX_LAST);
                end else begin
                    gap_nxt = gap_q - GAP_W'(1);
                end
            end

            ST_SEND: begin
                if (handshake) begin
                    word_nxt = word_q + DW'(1);
                    if (tlast_q) begin
                        // Frame complete: close it out and decide whether another follows.
                        tvalid_nxt = 1'b0;
                        tlast_nxt  = 1'b0;
                        beat_nxt   = '0;
                        done_nxt   = 1'b1;
                        fcnt_nxt   = fcnt_q + CNT_W'(1);
                        if (!CONTINUOUS || STOP) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_WAIT;
                            gap_nxt   = GAP_LOAD;
                        end
                    end else begin
                        beat_nxt  = beat_q + IDX_W'(1);
                        tdata_nxt = word_q + DW'(1);
                        tlast_nxt = ((beat_q + IDX_W'(1)) == IDX_LAST);
                    end
                end
            end

            default: begin
                state_nxt  = ST_IDLE;
                tvalid_nxt = 1'b0;
                tlast_nxt  = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state_q  <= ST_IDLE;
            gap_q    <= '0;
            beat_q   <= '0;
            word_q   <= DW'(1);
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_nxt;
            gap_q    <= gap_nxt;
            beat_q   <= beat_nxt;
            word_q   <= word_nxt;
            tvalid_q <= tvalid_nxt;
            tdata_q  <= tdata_nxt;
            tlast_q  <= tlast_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            fcnt_q   <= fcnt_nxt;
        end
    end

    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TSTRB  = {SW{1'b1}};
    assign M_AXIS_TLAST  = tlast_q;
    assign BUSY          = busy_q;
    assign FRAME_DONE    = done_q;
    assign FRAME_CNT     = fcnt_q;

endmodule

// File: tb/tb_axis_pattern_master.sv
// Bench for axis_pattern_master: three configurations, a per-cycle trace
// of the selected one, and a frame-level model of the expected beats.
module tb_axis_pattern_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, ready, stop, start_a, start_c, start_w;

    logic        a_valid, a_last, a_busy, a_done;
    logic [31:0] a_data;
    logic [3:0]  a_strb;
    logic [15:0] a_fcnt;
    logic        c_valid, c_last, c_busy, c_done;
    logic [31:0] c_data;
    logic [3:0]  c_strb;
    logic [15:0] c_fcnt;
    logic        w_valid, w_last, w_busy, w_done;
    logic [7:0]  w_data;
    logic [0:0]  w_strb;
    logic [15:0] w_fcnt;

    axis_pattern_master #(.C_M_AXIS_TDATA_WIDTH(32), .C_M_START_COUNT(4),
                          .C_NUM_WORDS(4), .C_MODE(0)) dut_a (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .START(start_a), .STOP(stop),
        .M_AXIS_TVALID(a_valid), .M_AXIS_TDATA(a_data), .M_AXIS_TSTRB(a_strb),
        .M_AXIS_TLAST(a_last), .M_AXIS_TREADY(ready), .BUSY(a_busy),
        .FRAME_DONE(a_done), .FRAME_CNT(a_fcnt));

    axis_pattern_master #(.C_M_AXIS_TDATA_WIDTH(32), .C_M_START_COUNT(4),
                          .C_NUM_WORDS(4), .C_MODE(1)) dut_c (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .START(start_c), .STOP(stop),
        .M_AXIS_TVALID(c_valid), .M_AXIS_TDATA(c_data), .M_AXIS_TSTRB(c_strb),
        .M_AXIS_TLAST(c_last), .M_AXIS_TREADY(ready), .BUSY(c_busy),
        .FRAME_DONE(c_done), .FRAME_CNT(c_fcnt));

    axis_pattern_master #(.C_M_AXIS_TDATA_WIDTH(8), .C_M_START_COUNT(2),
                          .C_NUM_WORDS(1), .C_MODE(1)) dut_w (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .START(start_w), .STOP(stop),
        .M_AXIS_TVALID(w_valid), .M_AXIS_TDATA(w_data), .M_AXIS_TSTRB(w_strb),
        .M_AXIS_TLAST(w_last), .M_AXIS_TREADY(ready), .BUSY(w_busy),
        .FRAME_DONE(w_done), .FRAME_CNT(w_fcnt));

    int          sel;
    logic        m_valid, m_last, m_done;
    logic [31:0] m_data;

    always_comb begin
        m_valid = a_valid; m_last = a_last; m_done = a_done; m_data = a_data;
        case (sel)
            1: begin m_valid = c_valid; m_last = c_last; m_done = c_done; m_data = c_data; end
            2: begin m_valid = w_valid; m_last = w_last; m_done = w_done; m_data = {24'd0, w_data}; end
            default: ;
        endcase
    end

    typedef struct packed {
        logic        rstn;
        logic        ready;
        logic        valid;
        logic        last;
        logic        done;
        logic [31:0] data;
    } smp_t;

    smp_t tr[$];

    // Mid-cycle snapshot: inputs here are the values the next rising edge sees.
    always @(negedge clk) tr.push_back({rstn, ready, m_valid, m_last, m_done, m_data});

    int          compared = 0;
    int          mismatched = 0;
    int unsigned hs_data[$];
    bit          hs_last[$];
    int          hs_cyc[$];
    int          base, lat, n;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks the trace: checks stall stability and FRAME_DONE timing, collects handshakes.
    task automatic analyze(input int from);
        smp_t c, p;
        hs_data.delete(); hs_last.delete(); hs_cyc.delete();
        for (int i = from; i < tr.size(); i++) begin
            c = tr[i];
            if (c.valid && c.ready && c.rstn) begin
                hs_data.push_back(c.data);
                hs_last.push_back(c.last);
                hs_cyc.push_back(i);
            end
            if (i > from) begin
                p = tr[i-1];
                if (p.valid && !p.ready && p.rstn) begin
                    chk("stall_valid", c.valid, 1);
                    chk("stall_data", c.data, p.data);
                    chk("stall_last", c.last, p.last);
                end
                chk("done_pulse", c.done, p.valid && p.ready && p.last && p.rstn);
            end
        end
    endtask

    // Expected beat k carries word first+k; TLAST closes every nwords beats.
    task automatic check_frames(input string tag, input int unsigned first, input int nframes,
                                input int nwords, input int unsigned mask, input bit b2b,
                                input int min_gap);
        int total, k_max;
        total = nframes * nwords;
        chk({tag, "_beats"}, hs_data.size(), total);
        k_max = (hs_data.size() < total) ? hs_data.size() : total;
        for (int k = 0; k < k_max; k++) begin
            chk({tag, "_data"}, hs_data[k], (first + k) & mask);
            chk({tag, "_last"}, hs_last[k], (k % nwords) == nwords - 1);
            if (k > 0 && (k % nwords) != 0 && b2b)
                chk({tag, "_b2b"}, hs_cyc[k] - hs_cyc[k-1], 1);
            if (k > 0 && (k % nwords) == 0)
                chk({tag, "_gap"}, 32'(hs_cyc[k] - hs_cyc[k-1] >= min_gap), 1);
        end
    endtask

    initial begin
        rstn = 0; ready = 0; stop = 0; start_a = 0; start_c = 0; start_w = 0; sel = 0;
        repeat (3) tick();

        chk("rst_valid", a_valid, 0);
        chk("rst_last", a_last, 0);
        chk("rst_data", a_data, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_fcnt", a_fcnt, 0);
        chk("strb_a", a_strb, 4'hF);
        chk("strb_c", c_strb, 4'hF);
        chk("strb_w", w_strb, 1);
        rstn = 1;
        tick();
        chk("first_valid", a_valid, 0);

        // Single frame, sink always ready.
        ready = 1;
        base = tr.size();
        start_a = 1; tick(); start_a = 0;
        chk("s1_busy", a_busy, 1);
        lat = 1;
        while (!a_valid && lat < 50) begin tick(); lat++; end
        chk("s1_latency", lat, 5);
        n = 0;
        while (!a_done && n < 50) begin tick(); n++; end
        chk("s1_done_seen", a_done, 1);
        chk("s1_fcnt", a_fcnt, 1);
        chk("s1_valid_fall", a_valid, 0);
        chk("s1_idle", a_busy, 0);
        repeat (3) tick();
        analyze(base);
        check_frames("s1", 1, 1, 4, 32'hFFFF_FFFF, 1, 0);

        // Same frame after reset, sink ready randomised.
        rstn = 0; tick(); rstn = 1; tick();
        base = tr.size();
        start_a = 1; ready = 1'($urandom_range(0, 1)); tick(); start_a = 0;
        n = 0;
        while (!a_done && n < 300) begin ready = 1'($urandom_range(0, 1)); tick(); n++; end
        chk("s2_done_seen", a_done, 1);
        chk("s2_fcnt", a_fcnt, 1);
        ready = 1;
        repeat (2) tick();
        analyze(base);
        check_frames("s2", 1, 1, 4, 32'hFFFF_FFFF, 0, 0);

        // Reset after the second handshake abandons the frame.
        rstn = 0; tick(); rstn = 1; tick();
        start_a = 1; tick(); start_a = 0;
        n = 0;
        while (!a_valid && n < 50) begin tick(); n++; end
        tick(); tick();
        chk("s3_mid_valid", a_valid, 1);
        chk("s3_mid_data", a_data, 3);
        rstn = 0; tick();
        chk("s3_rst_valid", a_valid, 0);
        chk("s3_rst_fcnt", a_fcnt, 0);
        chk("s3_rst_busy", a_busy, 0);
        rstn = 1; tick();
        base = tr.size();
        start_a = 1; tick(); start_a = 0;
        n = 0;
        while (!a_done && n < 50) begin tick(); n++; end
        chk("s3_fcnt", a_fcnt, 1);
        repeat (2) tick();
        analyze(base);
        check_frames("s3", 1, 1, 4, 32'hFFFF_FFFF, 1, 0);

        // START during WAIT and SEND must not queue a second frame.
        base = tr.size();
        start_a = 1; tick(); start_a = 0;
        tick();
        start_a = 1; tick(); start_a = 0;
        n = 0;
        while (!a_valid && n < 50) begin tick(); n++; end
        start_a = 1; tick(); start_a = 0;
        n = 0;
        while (!a_done && n < 50) begin tick(); n++; end
        chk("s4_fcnt", a_fcnt, 2);
        repeat (40) tick();
        chk("s4_idle", a_busy, 0);
        chk("s4_fcnt_hold", a_fcnt, 2);
        analyze(base);
        check_frames("s4", 5, 1, 4, 32'hFFFF_FFFF, 1, 0);

        // Continuous mode, STOP raised during the third frame.
        sel = 1;
        rstn = 0; tick(); rstn = 1; tick();
        base = tr.size();
        start_c = 1; tick(); start_c = 0;
        n = 0;
        while (!(c_fcnt == 16'd2 && c_valid) && n < 300) begin tick(); n++; end
        stop = 1;
        n = 0;
        while (!c_done && n < 50) begin tick(); n++; end
        chk("s5_fcnt", c_fcnt, 3);
        repeat (20) tick();
        stop = 0;
        chk("s5_idle", c_busy, 0);
        chk("s5_fcnt_hold", c_fcnt, 3);
        analyze(base);
        check_frames("s5", 1, 3, 4, 32'hFFFF_FFFF, 1, 5);

        // Byte-wide single-beat frames: 300 frames, data wraps past 0xFF.
        sel = 2;
        rstn = 0; tick(); rstn = 1; tick();
        base = tr.size();
        start_w = 1; tick(); start_w = 0;
        n = 0;
        while (!(w_fcnt == 16'd299 && w_valid) && n < 3000) begin tick(); n++; end
        stop = 1;
        n = 0;
        while (!w_done && n < 50) begin tick(); n++; end
        chk("s6_fcnt", w_fcnt, 300);
        repeat (5) tick();
        stop = 0;
        chk("s6_idle", w_busy, 0);
        analyze(base);
        check_frames("s6", 1, 300, 1, 32'h0000_00FF, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
